// File: rtl/mmc1_cfg_sequencer_pkg.sv
// Shared MMC1 sequencer definitions: register select codes, FSM states, shift length.
package mmc1_pkg;

  localparam logic [1:0] REG_CONTROL = 2'b00;
  localparam logic [1:0] REG_CHR0    = 2'b01;
  localparam logic [1:0] REG_CHR1    = 2'b10;
  localparam logic [1:0] REG_PRG     = 2'b11;

  localparam int MMC1_SHIFT_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RSTWR,
    ST_BITWR,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mmc1_cfg_sequencer_m2_phase_gen.sv
// Free-running M2 generator: HALF clocks low, HALF clocks high, registered output.
// Strobes are one cycle early: they mark the edge that starts the next low/high phase.
module m2_phase_gen #(
  parameter int HALF = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_m2,
  output logic o_lstart,
  output logic o_hstart
);

  localparam int PERIOD = 2 * HALF;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_m2;

  assign w_cnt_nxt = (r_cnt == CW'(PERIOD - 1)) ? '0 : r_cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_m2  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_m2  <= (w_cnt_nxt >= CW'(HALF));
    end
  end

  // Early strobes let the FSM register bus changes so they land with the M2 transition.
  assign o_lstart = (r_cnt == CW'(PERIOD - 1));
  assign o_hstart = (r_cnt == CW'(HALF - 1));
  assign o_m2     = r_m2;

endmodule

// File: rtl/mmc1_cfg_sequencer.sv
// Turns one {register, 5-bit value, optional reset} request into MMC1 serial bus writes.
// Transfer takes (RST+5)*(1+GAP_CYCLES) M2 periods after LSTART alignment; READY only in IDLE.
import mmc1_pkg::*;

module mmc1_cfg_sequencer #(
  parameter int HALF       = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_REG,
  input  logic [4:0] REQ_DATA,
  input  logic       REQ_RST,
  output logic       DONE,
  output logic       BUSY,
  output logic       CPU_M2,
  output logic       nCPU_ROMSEL,
  output logic       nCPU_RW,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D0,
  output logic       CPU_D7
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic          w_lstart;
  logic          w_hstart;
  state_t        r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_romsel_n;
  logic          r_rw_n;
  logic [1:0]    r_a;
  logic          r_d0;
  logic          r_d7;
  logic [2:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_reg;
  logic [4:0]    r_data;
  logic          r_rst;

  m2_phase_gen #(.HALF(HALF)) u_m2 (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .o_m2     (CPU_M2),
    .o_lstart (w_lstart),
    .o_hstart (w_hstart)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_romsel_n <= 1'b1;
      r_rw_n     <= 1'b1;
      r_a        <= 2'b00;
      r_d0       <= 1'b0;
      r_d7       <= 1'b0;
      r_idx      <= 3'd0;
      r_gap      <= '0;
      r_reg      <= 2'b00;
      r_data     <= 5'd0;
      r_rst      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID && r_ready) begin
            r_reg   <= REQ_REG;
            r_data  <= REQ_DATA;
            r_rst   <= REQ_RST;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_WAIT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_lstart) begin
            r_idx  <= 3'd0;
            r_rw_n <= 1'b0;
            r_a    <= r_reg;
            if (r_rst) begin
              r_d7    <= 1'b1;
              r_d0    <= 1'b0;
              r_state <= ST_RSTWR;
            end else begin
              r_d7    <= 1'b0;
              r_d0    <= r_data[0];
              r_state <= ST_BITWR;
            end
          end
        end
        ST_RSTWR, ST_BITWR: begin
          if (w_hstart) begin
            r_romsel_n <= 1'b0;
          end
          // Bus is left untouched on the falling M2 edge; GAP releases it one clock later.
          if (w_lstart) begin
            r_gap <= '0;
            if (r_state == ST_BITWR) begin
              r_idx <= r_idx + 3'd1;
            end
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_romsel_n <= 1'b1;
          r_rw_n     <= 1'b1;
          r_d0       <= 1'b0;
          r_d7       <= 1'b0;
          if (w_lstart) begin
            if (r_gap == GW'(GAP_CYCLES - 1)) begin
              if (r_idx < 3'(MMC1_SHIFT_LEN)) begin
                r_rw_n  <= 1'b0;
                r_d0    <= r_data[r_idx];
                r_state <= ST_BITWR;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY   = r_ready;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign nCPU_ROMSEL = r_romsel_n;
  assign nCPU_RW     = r_rw_n;
  assign CPU_A14     = r_a[1];
  assign CPU_A13     = r_a[0];
  assign CPU_D0      = r_d0;
  assign CPU_D7      = r_d7;

endmodule

// File: tb/tb_mmc1_cfg_sequencer.sv
// Bench for mmc1_cfg_sequencer: per-cycle reference model, MMC1 mapper model, directed and random requests.
import mmc1_pkg::*;

module tb_mmc1_cfg_sequencer;

  localparam int HALF = 4;
  localparam int GAPC = 1;
  localparam int P    = 2 * HALF;
  localparam int S    = 1 + GAPC;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_REG = 2'b00;
  logic [4:0] REQ_DATA = 5'd0;
  logic       REQ_RST = 1'b0;
  logic       DONE, BUSY, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;

  mmc1_cfg_sequencer #(.HALF(HALF), .GAP_CYCLES(GAPC)) dut (
    .CLK(CLK), .nRST(nRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_REG(REQ_REG), .REQ_DATA(REQ_DATA), .REQ_RST(REQ_RST),
    .DONE(DONE), .BUSY(BUSY), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
    .nCPU_RW(nCPU_RW), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13),
    .CPU_D0(CPU_D0), .CPU_D7(CPU_D7)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference model: global M2 phase plus a transfer offset t measured from the first LSTART.
  int         cyc = 0;
  bit         m_valid = 0;
  int         m_ph, m_mode, m_t, m_total;
  logic [1:0] m_reg;
  logic [4:0] m_data;
  logic       m_rst;
  logic       e_m2, e_rs, e_rw, e_d0, e_d7, e_ready, e_busy, e_done;
  logic [1:0] e_a;
  logic [4:0] exp_regs [4] = '{default: 5'd0};

  always @(posedge CLK) begin : model
    int p, ph, slot, pin, bi;
    cyc++;
    if (!nRST) begin
      m_valid = 1; m_ph = 0; m_mode = 0; m_t = 0;
      e_ready = 0; e_busy = 0; e_done = 0; e_a = 2'b00;
      e_rs = 1; e_rw = 1; e_d0 = 0; e_d7 = 0;
    end else begin
      m_ph   = (m_ph + 1) % P;
      e_done = 0;
      case (m_mode)
        0: if (e_ready && REQ_VALID) begin
             m_reg = REQ_REG; m_data = REQ_DATA; m_rst = REQ_RST;
             m_total = (m_rst ? 6 : 5) * S * P;
             m_mode = 1; e_busy = 1; e_ready = 0;
           end else e_ready = 1;
        1: if (m_ph == 0) begin m_mode = 2; m_t = 0; end
        2: m_t++;
        default: begin m_mode = 0; e_busy = 0; e_ready = 1; end
      endcase
      e_rs = 1; e_rw = 1; e_d0 = 0; e_d7 = 0;
      if (m_mode == 2) begin
        p = m_t / P; ph = m_t % P; slot = p / S; pin = p % S;
        e_a = m_reg;
        if ((m_t < m_total && pin == 0) || (pin == 1 && ph == 0)) begin
          e_rw = 0;
          e_rs = (pin == 0 && ph < HALF);
          if (m_rst && slot == 0) e_d7 = 1;
          else begin
            bi = m_rst ? slot - 1 : slot;
            e_d0 = m_data[bi];
          end
        end
        if (m_t == m_total) begin
          e_done = 1; exp_regs[m_reg] = m_data; m_mode = 3;
        end
      end
    end
    e_m2 = (m_ph >= HALF);
  end

  // Mapper model and per-cycle compare, sampled on the falling CLK edge.
  typedef struct packed { logic [1:0] a; logic d7; logic d0; } wr_t;
  wr_t        wlog[$];
  logic [4:0] mregs [4] = '{default: 5'd0};
  logic [4:0] msr = 5'd0;
  int         mcnt = 0;
  int         falls = 0, last_wr_fall = -10;
  logic       prev_m2 = 0, prev_rw = 1;
  bit         first_pending = 0;
  int         first_cyc = 0, done_cyc = 0, done_cnt = 0;

  always @(negedge CLK) begin
    logic [10:0] got, exp;
    if (m_valid) begin
      got = {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, REQ_READY, BUSY, DONE, 1'b0};
      exp = {e_m2, e_rs, e_rw, e_a, e_d0, e_d7, e_ready, e_busy, e_done, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        if (nprint < 20) $display("FAIL outputs cyc=%0d got=%b expected=%b", cyc, got, exp);
        nprint++;
      end
      if (prev_m2 && !CPU_M2) begin
        falls++;
        if (!nCPU_ROMSEL) begin
          check("rw_low_at_m2_fall", nCPU_RW, 0);
          check("write_spacing_ok", (falls - last_wr_fall) >= 2, 1);
          last_wr_fall = falls;
          wlog.push_back({CPU_A14, CPU_A13, CPU_D7, CPU_D0});
          if (CPU_D7) begin msr = 5'd0; mcnt = 0; end
          else begin
            msr = {CPU_D0, msr[4:1]}; mcnt++;
            if (mcnt == 5) begin mregs[{CPU_A14, CPU_A13}] = msr; msr = 5'd0; mcnt = 0; end
          end
        end
      end
      if (first_pending && prev_rw && !nCPU_RW) begin first_cyc = cyc; first_pending = 0; end
      if (DONE) begin
        done_cyc = cyc; done_cnt++;
        for (int r = 0; r < 4; r++) check("mapper_reg_vs_model", mregs[r], exp_regs[r]);
      end
    end
    prev_m2 = CPU_M2; prev_rw = nCPU_RW;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_req(input logic [1:0] r, input logic [4:0] d, input logic rs);
    int n = 0;
    while (!REQ_READY && n < 300) begin tick(); n++; end
    if (!REQ_READY) check("ready_timeout", 0, 1);
    REQ_VALID = 1; REQ_REG = r; REQ_DATA = d; REQ_RST = rs;
    tick();
    REQ_VALID = 0; REQ_REG = 2'($urandom); REQ_DATA = 5'($urandom); REQ_RST = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!DONE && n < 500) begin tick(); n++; end
    if (!DONE) check("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    logic [4:0] seq, old;
    int n, d0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", REQ_READY, 0);
    check("rst_m2", CPU_M2, 0);
    check("rst_romsel", nCPU_ROMSEL, 1);
    check("rst_rw", nCPU_RW, 1);
    check("rst_busy", BUSY, 0);
    nRST = 1;
    tick();
    check("ready_after_release", REQ_READY, 1);
    pat = 8'd0;
    for (int i = 0; i < 8; i++) begin pat = {pat[6:0], CPU_M2}; tick(); end
    check("m2_pattern", pat, 8'b00011110);

    // Plain load of CHR0.
    wlog.delete(); first_pending = 1;
    do_req(REG_CHR0, 5'b10110, 1'b0);
    wait_done();
    check("t1_writes", wlog.size(), 5);
    if (wlog.size() == 5) begin
      seq = 5'd0;
      for (int i = 0; i < 5; i++) begin
        seq[i] = wlog[i].d0;
        check("t1_addr", wlog[i].a, 2'b01);
        check("t1_d7", wlog[i].d7, 0);
      end
      check("t1_d0_seq", seq, 5'b10110);
    end
    check("t1_done_latency", done_cyc - first_cyc, 80);
    check("t1_mapper_chr0", mregs[1], 5'b10110);

    // Load with preceding reset write.
    wlog.delete(); first_pending = 1;
    do_req(REG_CONTROL, 5'b01100, 1'b1);
    wait_done();
    check("t2_writes", wlog.size(), 6);
    if (wlog.size() == 6) begin
      check("t2_first_d7", wlog[0].d7, 1);
      seq = 5'd0;
      for (int i = 0; i < 5; i++) seq[i] = wlog[i+1].d0;
      check("t2_d0_seq", seq, 5'b01100);
    end
    check("t2_period_count", done_cyc - first_cyc, 12 * P);
    check("t2_mapper_ctrl", mregs[0], 5'b01100);

    // Abort during the high phase of the third bit write.
    wlog.delete(); old = mregs[3];
    do_req(REG_PRG, 5'b10101, 1'b0);
    n = 0;
    while (!(wlog.size() == 2 && !nCPU_ROMSEL && CPU_M2) && n < 500) begin tick(); n++; end
    check("t3_reached_third_write", wlog.size() == 2 && !nCPU_ROMSEL, 1);
    nRST = 0;
    tick();
    check("t3_romsel", nCPU_ROMSEL, 1);
    check("t3_rw", nCPU_RW, 1);
    check("t3_m2", CPU_M2, 0);
    check("t3_busy", BUSY, 0);
    tick();
    nRST = 1;
    tick();
    check("t3_mapper_unchanged", mregs[3], old);
    do_req(REG_PRG, 5'b01011, 1'b1);
    wait_done();
    check("t3_reissue_prg", mregs[3], 5'b01011);

    // Valid pulses while busy are ignored.
    n = done_cnt;
    do_req(REG_CHR1, 5'b11001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      REQ_VALID = 1'($urandom); REQ_REG = 2'($urandom); REQ_DATA = 5'($urandom); REQ_RST = 1'($urandom);
      tick();
    end
    REQ_VALID = 0;
    wait_done();
    repeat (20) tick();
    check("t4_one_done", done_cnt - n, 1);
    check("t4_idle_after", BUSY, 0);
    check("t4_mapper_chr1", mregs[2], 5'b11001);

    // Random traffic, mostly back-to-back.
    d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      REQ_VALID = ($urandom % 4) != 0;
      REQ_REG = 2'($urandom); REQ_DATA = 5'($urandom); REQ_RST = 1'($urandom);
      tick();
    end
    REQ_VALID = 0;
    n = 0;
    while (BUSY && n < 500) begin tick(); n++; end
    check("rand_drained", BUSY, 0);
    check("rand_enough_transfers", (done_cnt - d0) >= 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
